syscall_decoder: RTL and testbench

Executes the MIPS `syscall` side effects for the single-cycle CPU. When the datapath asserts `enable` on a `syscall` instruction, the block decodes the service code in `v0`. It latches the argument `a0` onto the `hex` display register, or raises a sticky `halt` that stops the processor. It sits beside the register file and reads `$v0`/`$a0` combinationally; its outputs drive the seven-segment display and the PC-freeze logic.

---
 rtl/syscall_decoder.sv | 58 +++++
 tb/tb_syscall_decoder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/syscall_decoder.sv
// Executes MIPS syscall side effects: prints latch a0 onto the hex display, exits raise a sticky halt.
// One-cycle latency, no handshake; SYSCALL_EXT_EN adds the PRINT_CHAR, EXIT2 and PRINT_HEX services.
module syscall_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    input  logic        enable,
    output logic        halt,
    output logic [31:0] hex
);

    localparam logic [31:0] PRINT_INT  = 32'd1;
    localparam logic [31:0] EXIT       = 32'd10;
`ifdef SYSCALL_EXT_EN
    localparam logic [31:0] PRINT_CHAR = 32'd11;
    localparam logic [31:0] EXIT2      = 32'd17;
    localparam logic [31:0] PRINT_HEX  = 32'd34;
`endif

    logic        halt_q, halt_d;
    logic [31:0] hex_q, hex_d;

    // Full 32-bit compare: codes with any stray upper bits fall to the default arm.
    always_comb begin
        halt_d = halt_q;
        hex_d  = hex_q;
        if (enable && !halt_q) begin
            case (v0)
                PRINT_INT:  hex_d = a0;
                EXIT:       halt_d = 1'b1;
`ifdef SYSCALL_EXT_EN
                PRINT_CHAR: hex_d = {24'h0, a0[7:0]};
                EXIT2: begin
                    halt_d = 1'b1;
                    hex_d  = a0;
                end
                PRINT_HEX:  hex_d = a0;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_q <= 1'b0;
            hex_q  <= 32'h0000_0000;
        end else begin
            halt_q <= halt_d;
            hex_q  <= hex_d;
        end
    end

    assign halt = halt_q;
    assign hex  = hex_q;

endmodule

// File: tb/tb_syscall_decoder.sv
// Directed-vector bench for syscall_decoder; expectations follow the SYSCALL_EXT_EN build setting.
module tb_syscall_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        enable;
    logic        halt;
    logic [31:0] hex;

    int n_vec = 0;
    int n_err = 0;

    syscall_decoder dut (
        .clk    (clk),
        .rst    (rst),
        .v0     (v0),
        .a0     (a0),
        .enable (enable),
        .halt   (halt),
        .hex    (hex)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the following rising edge.
    task automatic apply(input logic [31:0] v, input logic [31:0] a, input logic e);
        @(negedge clk);
        v0     = v;
        a0     = a;
        enable = e;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic h, input logic [31:0] x);
        check({tag, ".halt"}, {31'd0, halt}, {31'd0, h});
        check({tag, ".hex"}, hex, x);
    endtask

    initial begin
        rst = 1'b1; v0 = '0; a0 = '0; enable = 1'b0;
        @(posedge clk); #1;
        expect_state("reset_held", 1'b0, 32'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        expect_state("reset_released", 1'b0, 32'h0);

        apply(32'd1, 32'h1234_5678, 1'b1);
        expect_state("print_int", 1'b0, 32'h1234_5678);

        apply(32'd10, 32'hDEAD_BEEF, 1'b1);
        expect_state("exit", 1'b1, 32'h1234_5678);

        apply(32'd0, 32'h0, 1'b0);
        expect_state("hold_after_exit", 1'b1, 32'h1234_5678);

        apply(32'd1, 32'hCAFE_BABE, 1'b1);
        expect_state("sticky_halt", 1'b1, 32'h1234_5678);

        // Asynchronous reset pulse between edges must clear state without a clock.
        #1 rst = 1'b1;
        #1;
        expect_state("async_reset", 1'b0, 32'h0);
        @(negedge clk); rst = 1'b0; enable = 1'b0;

        apply(32'h0000_0101, 32'hAAAA_AAAA, 1'b1);
        expect_state("upper_bits_ignored", 1'b0, 32'h0);

        apply(32'h8000_000A, 32'h5555_5555, 1'b1);
        expect_state("exit_upper_bit_ignored", 1'b0, 32'h0);

        apply(32'd1, 32'h0BAD_F00D, 1'b0);
        expect_state("enable_low_hold", 1'b0, 32'h0);

        // Back-to-back enabled edges execute in order.
        apply(32'd1, 32'h0000_00A5, 1'b1);
        expect_state("b2b_first", 1'b0, 32'h0000_00A5);
        apply(32'd34, 32'h1357_9BDF, 1'b1);
`ifdef SYSCALL_EXT_EN
        expect_state("b2b_print_hex", 1'b0, 32'h1357_9BDF);
`else
        expect_state("b2b_print_hex", 1'b0, 32'h0000_00A5);
`endif

        // Reset wins over a simultaneous enabled syscall.
        @(negedge clk);
        rst = 1'b1; v0 = 32'd1; a0 = 32'hFFFF_FFFF; enable = 1'b1;
        @(posedge clk); #1;
        expect_state("reset_wins", 1'b0, 32'h0);
        @(negedge clk); rst = 1'b0; enable = 1'b0;

        apply(32'd11, 32'h0000_01F4, 1'b1);
`ifdef SYSCALL_EXT_EN
        expect_state("print_char", 1'b0, 32'h0000_00F4);
`else
        expect_state("print_char", 1'b0, 32'h0);
`endif

        apply(32'd17, 32'h0000_0003, 1'b1);
`ifdef SYSCALL_EXT_EN
        expect_state("exit2", 1'b1, 32'h0000_0003);
`else
        expect_state("exit2", 1'b0, 32'h0);
`endif

        apply(32'd10, 32'h0, 1'b1);
        apply(32'd1, 32'h7777_7777, 1'b1);
`ifdef SYSCALL_EXT_EN
        expect_state("halted_print", 1'b1, 32'h0000_0003);
`else
        expect_state("halted_print", 1'b1, 32'h0);
`endif

        @(negedge clk); rst = 1'b1; enable = 1'b0;
        @(negedge clk); rst = 1'b0;
        apply(32'd1, 32'h2468_ACE0, 1'b1);
        expect_state("resume_after_reset", 1'b0, 32'h2468_ACE0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
